// File: rtl/fp16_pkg.sv
// Shared FP16 field definitions, constants and operand classification.
package fp16_pkg;

    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned BIAS   = 15;

    localparam logic [15:0]      FP16_QNAN    = 16'h7E00;
    localparam logic [EXP_W-1:0] FP16_EXP_MAX = 5'h1F;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    // Subnormals are flushed, so they classify as zero.
    function automatic fp_class_e fp16_classify(input fp16_t x);
        if (x.exp == FP16_EXP_MAX) begin
            return (x.frac == '0) ? FP_INF : FP_NAN;
        end else if (x.exp == '0) begin
            return FP_ZERO;
        end
        return FP_NORMAL;
    endfunction

    function automatic logic fp16_is_subnormal(input fp16_t x);
        return (x.exp == '0) && (x.frac != '0);
    endfunction

endpackage

// File: rtl/fp16_div_round_pack.sv
// Combinational round-to-nearest-even, range check and special-case packing
// of the raw restoring-division quotient.
module fp16_div_round_pack
    import fp16_pkg::*;
(
    input  logic [12:0]       q_i,
    input  logic              rem_nz_i,
    input  logic signed [6:0] exp_i,
    input  logic              sign_i,
    input  logic [1:0]        cls1_i,
    input  logic [1:0]        cls2_i,
    input  logic              ftz1_i,
    input  logic              ftz2_i,
    output logic [15:0]       result_c_o,
    output logic              overflow_c_o,
    output logic              zero_c_o,
    output logic              nan_c_o,
    output logic              prec_lost_c_o
);

    logic              nan_case;
    logic              inf_case;
    logic              zero_case;
    logic              ftz_lost;
    logic              guard;
    logic              sticky;
    logic              carry;
    logic [9:0]        frac_sel;
    logic [9:0]        frac_rnd;
    logic signed [6:0] e;

    always_comb begin
        result_c_o    = '0;
        overflow_c_o  = 1'b0;
        zero_c_o      = 1'b0;
        nan_c_o       = 1'b0;
        prec_lost_c_o = 1'b0;

        nan_case  = (cls1_i == FP_NAN) || (cls2_i == FP_NAN) ||
                    ((cls1_i == FP_ZERO) && (cls2_i == FP_ZERO)) ||
                    ((cls1_i == FP_INF) && (cls2_i == FP_INF));
        inf_case  = (cls1_i == FP_INF) || ((cls1_i == FP_NORMAL) && (cls2_i == FP_ZERO));
        zero_case = (cls1_i == FP_ZERO) || (cls2_i == FP_INF);
        // A flushed operand only matters when the other one does not already force the result.
        ftz_lost  = (ftz1_i && (cls2_i != FP_INF)) || (ftz2_i && (cls1_i != FP_INF));

        // Normalise: quotient lies in [0.5, 2), so at most one position of shift.
        if (q_i[12]) begin
            frac_sel = q_i[11:2];
            guard    = q_i[1];
            sticky   = q_i[0] | rem_nz_i;
            e        = exp_i;
        end else begin
            frac_sel = q_i[10:1];
            guard    = q_i[0];
            sticky   = rem_nz_i;
            e        = exp_i - 7'sd1;
        end

        {carry, frac_rnd} = {1'b0, frac_sel} + 11'(guard & (sticky | frac_sel[0]));
        if (carry) begin
            e = e + 7'sd1;
        end

        if (nan_case) begin
            result_c_o = FP16_QNAN;
            nan_c_o    = 1'b1;
        end else if (inf_case) begin
            result_c_o    = {sign_i, FP16_EXP_MAX, 10'h0};
            overflow_c_o  = 1'b1;
            prec_lost_c_o = ftz_lost;
        end else if (zero_case) begin
            result_c_o    = {sign_i, 15'h0};
            zero_c_o      = 1'b1;
            prec_lost_c_o = ftz_lost;
        end else if (e >= 7'sd31) begin
            result_c_o    = {sign_i, FP16_EXP_MAX, 10'h0};
            overflow_c_o  = 1'b1;
            prec_lost_c_o = 1'b1;
        end else if (e <= 7'sd0) begin
            result_c_o    = {sign_i, 15'h0};
            zero_c_o      = 1'b1;
            prec_lost_c_o = 1'b1;
        end else begin
            result_c_o    = {sign_i, e[4:0], frac_rnd};
            prec_lost_c_o = guard | sticky;
        end
    end

endmodule

// File: rtl/float_div_iterative.sv
// Iterative FP16 divider: one restoring-division quotient bit per cycle,
// valid/ready handshake on both sides, fixed latency for all operands.
module float_div_iterative
    import fp16_pkg::*;
#(
    parameter int unsigned QBITS = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [15:0] num1,
    input  logic [15:0] num2,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [15:0] result,
    output logic        overflow,
    output logic        zero,
    output logic        NaN,
    output logic        precisionLost
);

    localparam int unsigned      CNT_W    = $clog2(QBITS + 1);
    localparam logic [QBITS-1:0] LOW_MASK = (QBITS'(1) << (QBITS - 13)) - QBITS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    fp16_t             a_q, a_d, b_q, b_d;
    logic [11:0]       rem_q, rem_d;
    logic [QBITS-1:0]  q_q, q_d;
    logic signed [6:0] exp_q, exp_d;
    logic [15:0]       result_q, result_d;
    logic              ovf_q, ovf_d, zero_q, zero_d, nan_q, nan_d, pl_q, pl_d;
    logic              valid_out_q, valid_out_d, ready_in_q, ready_in_d;

    logic [11:0]       mb;
    logic              iter_bit;
    logic [11:0]       rem_sub;
    logic [11:0]       rem_iter;
    logic [QBITS-1:0]  q_iter;
    logic              rem_nz;
    fp_class_e         cls1, cls2;
    logic [15:0]       pk_result;
    logic              pk_ovf, pk_zero, pk_nan, pk_pl;

    // One restoring step: compare, conditionally subtract, shift.
    assign mb       = {1'b0, 1'b1, b_q.frac};
    assign iter_bit = (rem_q >= mb);
    assign rem_sub  = iter_bit ? (rem_q - mb) : rem_q;
    assign rem_iter = 12'({rem_sub, 1'b0});
    assign q_iter   = QBITS'({q_q, iter_bit});
    assign rem_nz   = (rem_iter != 12'd0) || ((q_iter & LOW_MASK) != '0);

    assign cls1 = fp16_classify(a_q);
    assign cls2 = fp16_classify(b_q);

    fp16_div_round_pack u_round_pack (
        .q_i           (q_iter[QBITS-1 -: 13]),
        .rem_nz_i      (rem_nz),
        .exp_i         (exp_q),
        .sign_i        (a_q.sign ^ b_q.sign),
        .cls1_i        (cls1),
        .cls2_i        (cls2),
        .ftz1_i        (fp16_is_subnormal(a_q)),
        .ftz2_i        (fp16_is_subnormal(b_q)),
        .result_c_o    (pk_result),
        .overflow_c_o  (pk_ovf),
        .zero_c_o      (pk_zero),
        .nan_c_o       (pk_nan),
        .prec_lost_c_o (pk_pl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            exp_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            nan_q       <= 1'b0;
            pl_q        <= 1'b0;
            valid_out_q <= 1'b0;
            ready_in_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            exp_q       <= exp_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            nan_q       <= nan_d;
            pl_q        <= pl_d;
            valid_out_q <= valid_out_d;
            ready_in_q  <= ready_in_d;
        end
    end

    // Count 0 is a setup cycle; counts 1..QBITS each retire one quotient bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        q_d      = q_q;
        exp_d    = exp_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        nan_d    = nan_q;
        pl_d     = pl_q;

        case (state_q)
            S_IDLE: begin
                if (valid_in && ready_in_q) begin
                    state_d = S_DIV;
                    a_d     = num1;
                    b_d     = num2;
                    cnt_d   = '0;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    rem_d = {1'b0, 1'b1, a_q.frac};
                    q_d   = '0;
                    exp_d = $signed({2'b00, a_q.exp}) - $signed({2'b00, b_q.exp})
                            + $signed(7'(BIAS));
                    cnt_d = CNT_W'(1);
                end else begin
                    rem_d = rem_iter;
                    q_d   = q_iter;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(QBITS)) begin
                        state_d  = S_DONE;
                        cnt_d    = '0;
                        result_d = pk_result;
                        ovf_d    = pk_ovf;
                        zero_d   = pk_zero;
                        nan_d    = pk_nan;
                        pl_d     = pk_pl;
                    end
                end
            end
            S_DONE: begin
                if (ready_out) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_out_d = (state_d == S_DONE);
        ready_in_d  = (state_d == S_IDLE);
    end

    assign ready_in      = ready_in_q;
    assign valid_out     = valid_out_q;
    assign result        = result_q;
    assign overflow      = ovf_q;
    assign zero          = zero_q;
    assign NaN           = nan_q;
    assign precisionLost = pl_q;

endmodule

// File: tb/tb_float_div_iterative.sv
// Directed bench for float_div_iterative: vector table plus backpressure
// and asynchronous-reset sequences.
module tb_float_div_iterative;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flags;   // {overflow, zero, NaN, precisionLost}
    } vec_t;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic [15:0] num1;
    logic [15:0] num2;
    logic        valid_out;
    logic        ready_out;
    logic [15:0] result;
    logic        overflow;
    logic        zero;
    logic        NaN;
    logic        precisionLost;

    int checks   = 0;
    int failures = 0;

    float_div_iterative #(.QBITS(13)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .ready_in      (ready_in),
        .num1          (num1),
        .num2          (num2),
        .valid_out     (valid_out),
        .ready_out     (ready_out),
        .result        (result),
        .overflow      (overflow),
        .zero          (zero),
        .NaN           (NaN),
        .precisionLost (precisionLost)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] flags_now();
        return 16'({overflow, zero, NaN, precisionLost});
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        valid_in = 1'b1;
        num1     = a;
        num2     = b;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Latency in edges after the accept edge; 0 means it never came.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (valid_out) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic [3:0] exp_fl,
                          input string name);
        int lat;
        ready_out = 1'b1;
        for (int k = 0; k < 40 && ready_in !== 1'b1; k++) @(negedge clk);
        check({name, " ready_in before"}, 16'(ready_in), 16'd1);
        issue(a, b);
        wait_valid(lat);
        check({name, " latency"}, 16'(lat), 16'd14);
        check({name, " result"}, result, exp_res);
        check({name, " flags"}, flags_now(), 16'(exp_fl));
        @(posedge clk);
        #1;
        check({name, " ready_in after"}, 16'(ready_in), 16'd1);
        check({name, " valid_out after"}, 16'(valid_out), 16'd0);
    endtask

    initial begin
        vec_t vecs[13];
        int   lat;

        vecs[0]  = '{16'h4000, 16'h3C00, 16'h4000, 4'b0000};  // 2 / 1
        vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, 4'b0001};  // 1 / 3
        vecs[2]  = '{16'hC000, 16'h3800, 16'hC400, 4'b0000};  // -2 / 0.5
        vecs[3]  = '{16'h3C00, 16'h0000, 16'h7C00, 4'b1000};  // 1 / 0
        vecs[4]  = '{16'h0000, 16'h0000, 16'h7E00, 4'b0010};  // 0 / 0
        vecs[5]  = '{16'h7C00, 16'h7C00, 16'h7E00, 4'b0010};  // inf / inf
        vecs[6]  = '{16'h8000, 16'h4000, 16'h8000, 4'b0100};  // -0 / 2
        vecs[7]  = '{16'h7BFF, 16'h0400, 16'h7C00, 4'b1001};  // max / min normal
        vecs[8]  = '{16'h0400, 16'h7BFF, 16'h0000, 4'b0101};  // min normal / max
        vecs[9]  = '{16'h0001, 16'h3C00, 16'h0000, 4'b0101};  // subnormal flushed
        vecs[10] = '{16'h3C00, 16'h3BFF, 16'h3C01, 4'b0001};  // rounds up
        vecs[11] = '{16'h7E00, 16'h3C00, 16'h7E00, 4'b0010};  // NaN input
        vecs[12] = '{16'h3C00, 16'hC000, 16'hB800, 4'b0000};  // 1 / -2

        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        num1      = '0;
        num2      = '0;
        #2;
        check("reset ready_in", 16'(ready_in), 16'd1);
        check("reset valid_out", 16'(valid_out), 16'd0);
        check("reset result", result, 16'h0000);
        check("reset flags", flags_now(), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags, $sformatf("vec%0d", i));
        end

        // Backpressure: result held while ready_out is low, stray valid_in ignored.
        ready_out = 1'b0;
        issue(16'h3C00, 16'h4200);
        wait_valid(lat);
        check("bp latency", 16'(lat), 16'd14);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                valid_in = 1'b1;
                num1     = 16'h4000;
                num2     = 16'h3C00;
            end
            if (c == 2) begin
                valid_in = 1'b0;
            end
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d result", c), result, 16'h3555);
            check($sformatf("bp hold%0d flags", c), flags_now(), 16'h0001);
            check($sformatf("bp hold%0d valid_out", c), 16'(valid_out), 16'd1);
            check($sformatf("bp hold%0d ready_in", c), 16'(ready_in), 16'd0);
        end
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        check("bp release valid_out", 16'(valid_out), 16'd0);
        check("bp release ready_in", 16'(ready_in), 16'd1);
        @(posedge clk);
        #1;
        check("bp no stray accept", 16'(ready_in), 16'd1);
        run_op(16'h4400, 16'h4000, 16'h4000, 4'b0000, "bp next");

        // Asynchronous reset between edges after the sixth iteration.
        issue(16'h4000, 16'h3C00);
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async rst valid_out", 16'(valid_out), 16'd0);
        check("async rst result", result, 16'h0000);
        check("async rst flags", flags_now(), 16'h0000);
        check("async rst ready_in", 16'(ready_in), 16'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h4000, 16'h3C00, 16'h4000, 4'b0000, "post rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
